// File: rtl/ctrl_serial_pkg.sv
// Shared types and constants for the serial-to-Wishbone controller.
package ctrl_serial_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWrData,
      StWbReq,
      StTxData,
      StTxStatus
   } state_e;

   localparam logic [7:0] STATUS_OK      = 8'h01;
   localparam logic [7:0] STATUS_ERR     = 8'h02;
   localparam logic [7:0] STATUS_TIMEOUT = 8'h03;

   // Command byte layout: bit7 = write, bits[3:0] = burst length - 1.
   localparam int unsigned CMD_WE_BIT  = 7;
   localparam int unsigned CMD_LEN_MSB = 3;

endpackage

// File: rtl/ctrl_serial_timeout.sv
// Bus watchdog: counts enabled cycles since the last clear and flags the cycle
// that would be the TIMEOUT-th enabled one, so the master can abort on that edge.
module ctrl_serial_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count enabled cycles and saturate.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CntW'(TIMEOUT))) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && !clr_i && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/ctrl_serial_wb.sv
// Byte-stream command decoder driving single-outstanding classic Wishbone cycles.
// Frames: cmd, address (MSB first), optional write data; every frame answers with
// optional read data followed by one status byte.
module ctrl_serial_wb
   import ctrl_serial_pkg::*;
#(
   parameter int unsigned ADR_BYTES = 2,
   parameter int unsigned DAT_BYTES = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   wb_cyc_o,
   output logic                   wb_stb_o,
   output logic                   wb_we_o,
   output logic [8*ADR_BYTES-1:0] wb_adr_o,
   output logic [8*DAT_BYTES-1:0] wb_dat_o,
   output logic [DAT_BYTES-1:0]   wb_sel_o,
   input  logic [8*DAT_BYTES-1:0] wb_dat_i,
   input  logic                   wb_ack_i,
   input  logic                   wb_err_i,
   input  logic                   rx_valid_i,
   input  logic [7:0]             rx_data_i,
   output logic                   rx_ready_o,
   output logic                   tx_valid_o,
   output logic [7:0]             tx_data_o,
   input  logic                   tx_ready_i
);

   localparam int unsigned AW   = 8 * ADR_BYTES;
   localparam int unsigned DW   = 8 * DAT_BYTES;
   localparam int unsigned MaxB = (ADR_BYTES > DAT_BYTES) ? ADR_BYTES : DAT_BYTES;
   localparam int unsigned BcW  = $clog2(MaxB + 1);

   state_e          state_q, state_d;
   logic            we_q, we_d;
   logic [3:0]      len_q, len_d;     // words remaining after the current one
   logic [BcW-1:0]  bcnt_q, bcnt_d;   // byte index within address or data word
   logic [AW-1:0]   adr_q, adr_d;
   logic [DW-1:0]   wdat_q, wdat_d;
   logic [DW-1:0]   txsh_q, txsh_d;
   logic [7:0]      status_q, status_d;
   logic            cyc_q, cyc_d;
   logic            rx_ready;
   logic            tx_valid;
   logic [7:0]      tx_data;
   logic            wd_expired;

   // Watchdog runs only while the strobe is out; it is held clear elsewhere so
   // every request starts from zero.
   ctrl_serial_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (state_q != StWbReq),
      .en_i      (cyc_q),
      .expired_o (wd_expired)
   );

   // Next-state and handshake decode.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      len_d    = len_q;
      bcnt_d   = bcnt_q;
      adr_d    = adr_q;
      wdat_d   = wdat_q;
      txsh_d   = txsh_q;
      status_d = status_q;
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      unique case (state_q)
         StIdle: begin
            rx_ready = 1'b1;
            if (rx_valid_i) begin
               we_d    = rx_data_i[CMD_WE_BIT];
               len_d   = rx_data_i[CMD_LEN_MSB:0];
               bcnt_d  = '0;
               state_d = StAddr;
            end
         end
         StAddr: begin
            rx_ready = 1'b1;
            if (rx_valid_i) begin
               adr_d = AW'({adr_q, rx_data_i});
               if (bcnt_q == BcW'(ADR_BYTES - 1)) begin
                  bcnt_d  = '0;
                  state_d = we_q ? StWrData : StWbReq;
               end else begin
                  bcnt_d = bcnt_q + BcW'(1);
               end
            end
         end
         StWrData: begin
            rx_ready = 1'b1;
            if (rx_valid_i) begin
               wdat_d = DW'({wdat_q, rx_data_i});
               if (bcnt_q == BcW'(DAT_BYTES - 1)) begin
                  bcnt_d  = '0;
                  state_d = StWbReq;
               end else begin
                  bcnt_d = bcnt_q + BcW'(1);
               end
            end
         end
         StWbReq: begin
            // Responses only count while the strobe is actually out; err beats ack,
            // and either beats a watchdog expiring in the same cycle.
            if (cyc_q && wb_err_i) begin
               status_d = STATUS_ERR;
               state_d  = StTxStatus;
            end else if (cyc_q && wb_ack_i) begin
               adr_d = adr_q + AW'(1);
               if (!we_q) begin
                  txsh_d  = wb_dat_i;
                  bcnt_d  = '0;
                  state_d = StTxData;
               end else if (len_q == 4'd0) begin
                  status_d = STATUS_OK;
                  state_d  = StTxStatus;
               end else begin
                  len_d   = len_q - 4'd1;
                  bcnt_d  = '0;
                  state_d = StWrData;
               end
            end else if (wd_expired) begin
               status_d = STATUS_TIMEOUT;
               state_d  = StTxStatus;
            end
         end
         StTxData: begin
            tx_valid = 1'b1;
            tx_data  = txsh_q[DW-1 -: 8];
            if (tx_ready_i) begin
               txsh_d = txsh_q << 8;
               if (bcnt_q == BcW'(DAT_BYTES - 1)) begin
                  bcnt_d = '0;
                  if (len_q == 4'd0) begin
                     status_d = STATUS_OK;
                     state_d  = StTxStatus;
                  end else begin
                     len_d   = len_q - 4'd1;
                     state_d = StWbReq;
                  end
               end else begin
                  bcnt_d = bcnt_q + BcW'(1);
               end
            end
         end
         StTxStatus: begin
            tx_valid = 1'b1;
            tx_data  = status_q;
            if (tx_ready_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Strobe is registered from the next state so it rises on entry to a request
      // and drops on the edge that leaves it.
      cyc_d = (state_d == StWbReq);
   end

   // State and datapath registers; reset discards any partial frame or bus cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         len_q    <= '0;
         bcnt_q   <= '0;
         adr_q    <= '0;
         wdat_q   <= '0;
         txsh_q   <= '0;
         status_q <= '0;
         cyc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         len_q    <= len_d;
         bcnt_q   <= bcnt_d;
         adr_q    <= adr_d;
         wdat_q   <= wdat_d;
         txsh_q   <= txsh_d;
         status_q <= status_d;
         cyc_q    <= cyc_d;
      end
   end

   assign wb_cyc_o   = cyc_q;
   assign wb_stb_o   = cyc_q;
   assign wb_we_o    = cyc_q & we_q;
   assign wb_sel_o   = {DAT_BYTES{cyc_q}};
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = wdat_q;
   // No byte is taken while reset is held.
   assign rx_ready_o = rx_ready & ~rst_i;
   assign tx_valid_o = tx_valid;
   assign tx_data_o  = tx_data;

endmodule

// File: tb/tb_ctrl_serial_wb.sv
// Randomised bench for ctrl_serial_wb with a frame-level reference model.
module tb_ctrl_serial_wb;

   localparam int unsigned ADR_BYTES = 2;
   localparam int unsigned DAT_BYTES = 4;
   localparam int unsigned TIMEOUT   = 255;
   localparam int R_ACK = 0, R_ERR = 1, R_BOTH = 2, R_NONE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [15:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i, wb_err_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready_i;

   always #5 clk = ~clk;

   ctrl_serial_wb #(
      .ADR_BYTES (ADR_BYTES),
      .DAT_BYTES (DAT_BYTES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_sel_o   (wb_sel_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i),
      .rx_valid_i (rx_valid_i),
      .rx_data_i  (rx_data_i),
      .rx_ready_o (rx_ready_o),
      .tx_valid_o (tx_valid_o),
      .tx_data_o  (tx_data_o),
      .tx_ready_i (tx_ready_i)
   );

   int n_tot = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame description shared by the directed and random phases.
   logic        f_we;
   int          f_n;
   logic [2:0]  f_resv;
   logic [15:0] f_adr;
   logic [31:0] f_wd[16];
   logic [31:0] f_rd[16];
   int          f_resp[16];
   int          f_dly;
   int          f_txr;   // 0 always ready, 1 random, 2 ten-cycle stall per byte
   int          f_gap;   // percent of cycles the rx source idles
   bit          f_spur;  // stray ack/err while strobe is low

   task automatic set_frame(input logic we, input int n, input logic [15:0] adr, input int dly,
                            input int txr, input int gap, input bit spur);
      f_we = we; f_n = n; f_adr = adr; f_dly = dly; f_txr = txr; f_gap = gap; f_spur = spur;
      f_resv = 3'd0;
      for (int i = 0; i < 16; i++) begin
         f_wd[i]   = $urandom;
         f_rd[i]   = $urandom;
         f_resp[i] = R_ACK;
      end
   endtask

   task automatic run_frame(input string tag);
      logic [7:0]  exp_tx[$];
      logic [7:0]  rxq[$];
      logic [7:0]  got_tx[$];
      logic [15:0] bc_adr[$];
      logic        bc_we[$];
      logic [31:0] bc_dat[$];
      logic [3:0]  bc_sel[$];
      logic        bc_cyc[$];
      int          bc_len[$];
      int          nb, rx_idx, req, stb_len, cyc, first_txv, term_at_txv, last_term, txr_cnt, k;
      int          ntx, lat_beat;
      logic [7:0]  st, prev_txd;
      logic [15:0] ea;
      logic        stb_prev, prev_txv, prev_txr;

      // Reference: walk the burst, stop at the first failing beat.
      nb = 0;
      st = 8'h01;
      rxq.push_back({f_we, f_resv, 4'(f_n - 1)});
      rxq.push_back(f_adr[15:8]);
      rxq.push_back(f_adr[7:0]);
      for (int i = 0; i < f_n; i++) begin
         nb++;
         if (f_we) for (int b = 3; b >= 0; b--) rxq.push_back(f_wd[i][8*b +: 8]);
         if (f_resp[i] == R_ERR || f_resp[i] == R_BOTH) begin st = 8'h02; break; end
         if (f_resp[i] == R_NONE) begin st = 8'h03; break; end
         if (!f_we) for (int b = 3; b >= 0; b--) exp_tx.push_back(f_rd[i][8*b +: 8]);
      end
      exp_tx.push_back(st);

      rx_idx = 0; req = 0; stb_len = 0; cyc = 0; txr_cnt = 0;
      first_txv = -1; term_at_txv = -1; last_term = -1;
      stb_prev = 1'b0; prev_txv = 1'b0; prev_txr = 1'b0; prev_txd = 8'h00;

      @(posedge clk); #1;
      while (got_tx.size() < exp_tx.size() && cyc < 20000) begin
         // Drive host, sink and slave for this cycle.
         if (rx_idx < rxq.size()) begin
            rx_valid_i = ($urandom_range(99) >= f_gap);
            rx_data_i  = rxq[rx_idx];
         end else begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
         end
         if (f_txr == 0)      tx_ready_i = 1'b1;
         else if (f_txr == 1) tx_ready_i = 1'($urandom_range(1));
         else                 tx_ready_i = (txr_cnt >= 10);
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         wb_dat_i = $urandom;
         if (wb_stb_o) begin
            k = stb_prev ? stb_len : 0;
            if (req < f_n && k >= f_dly && f_resp[req] != R_NONE) begin
               wb_ack_i = (f_resp[req] == R_ACK || f_resp[req] == R_BOTH);
               wb_err_i = (f_resp[req] == R_ERR || f_resp[req] == R_BOTH);
               if (wb_ack_i) wb_dat_i = f_rd[req];
            end
         end else if (f_spur) begin
            wb_ack_i = ($urandom_range(7) == 0);
            wb_err_i = ($urandom_range(15) == 0);
         end

         @(negedge clk);
         if (rx_valid_i && rx_ready_o) rx_idx++;
         if (tx_valid_o) begin
            if (first_txv < 0) begin
               first_txv   = cyc;
               term_at_txv = last_term;
            end
            if (prev_txv && !prev_txr) check_eq({tag, "/tx_hold"}, 64'(tx_data_o), 64'(prev_txd));
            if (tx_ready_i) begin
               got_tx.push_back(tx_data_o);
               txr_cnt = 0;
            end else begin
               txr_cnt++;
            end
         end
         prev_txv = tx_valid_o; prev_txr = tx_ready_i; prev_txd = tx_data_o;
         if (wb_stb_o) begin
            if (!stb_prev) begin
               bc_adr.push_back(wb_adr_o);
               bc_we.push_back(wb_we_o);
               bc_dat.push_back(wb_dat_o);
               bc_sel.push_back(wb_sel_o);
               bc_cyc.push_back(wb_cyc_o);
            end
            stb_len++;
            if (wb_ack_i || wb_err_i) last_term = cyc;
         end else if (stb_prev) begin
            bc_len.push_back(stb_len);
            stb_len = 0;
            req++;
         end
         stb_prev = wb_stb_o;

         @(posedge clk); #1;
         cyc++;
      end
      rx_valid_i = 1'b0;
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      tx_ready_i = 1'b0;

      check_eq({tag, "/done"}, 64'(got_tx.size()), 64'(exp_tx.size()));
      ntx = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
      for (int i = 0; i < ntx; i++)
         check_eq($sformatf("%s/tx%0d", tag, i), 64'(got_tx[i]), 64'(exp_tx[i]));
      check_eq({tag, "/rx_used"}, 64'(rx_idx), 64'(rxq.size()));
      check_eq({tag, "/ncyc"}, 64'(bc_adr.size()), 64'(nb));
      for (int i = 0; i < bc_adr.size() && i < nb; i++) begin
         ea = f_adr + 16'(i);
         check_eq($sformatf("%s/adr%0d", tag, i), 64'(bc_adr[i]), 64'(ea));
         check_eq($sformatf("%s/we%0d", tag, i), 64'(bc_we[i]), 64'(f_we));
         check_eq($sformatf("%s/sel%0d", tag, i), 64'({bc_cyc[i], bc_sel[i]}), 64'(5'h1F));
         if (f_we) check_eq($sformatf("%s/dat%0d", tag, i), 64'(bc_dat[i]), 64'(f_wd[i]));
         if (i < bc_len.size())
            check_eq($sformatf("%s/len%0d", tag, i), 64'(bc_len[i]),
                     64'((f_resp[i] == R_NONE) ? TIMEOUT : f_dly + 1));
      end
      // First tx byte follows the deciding ack/err by exactly one cycle.
      lat_beat = f_we ? nb - 1 : 0;
      if (f_resp[lat_beat] != R_NONE && last_term >= 0)
         check_eq({tag, "/lat"}, 64'(first_txv), 64'(term_at_txv + 1));
   endtask

   logic [7:0] part[2];

   initial begin
      rst = 1'b1;
      rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_ready_i = 1'b0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset/wb", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'(0));
      check_eq("reset/tx", 64'({tx_valid_o, tx_data_o}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle/rx_ready", 64'(rx_ready_o), 64'(1));

      set_frame(1'b1, 1, 16'h0010, 2, 0, 0, 1'b0);
      f_wd[0] = 32'hDEADBEEF;
      run_frame("wr1");

      set_frame(1'b0, 2, 16'h0020, 0, 0, 0, 1'b0);
      f_rd[0] = 32'h11223344; f_rd[1] = 32'h55667788;
      run_frame("rd2");

      set_frame(1'b0, 1, 16'h1234, 0, 0, 0, 1'b0);
      f_resp[0] = R_NONE;
      run_frame("tmo");
      set_frame(1'b0, 1, 16'h4321, 1, 0, 0, 1'b0);
      run_frame("after_tmo");

      set_frame(1'b0, 3, 16'h0100, 1, 0, 0, 1'b0);
      f_resp[1] = R_ERR;
      run_frame("err_mid");
      set_frame(1'b0, 3, 16'h0200, 0, 0, 0, 1'b0);
      f_resp[1] = R_BOTH;
      run_frame("err_ack");

      set_frame(1'b0, 2, 16'hFFFF, 0, 2, 0, 1'b0);
      run_frame("wrap_stall");

      // Partial frame then reset.
      part[0] = 8'h80; part[1] = 8'h00;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         rx_valid_i = 1'b1;
         rx_data_i  = part[i];
         @(negedge clk);
         check_eq("rstmid/rx_ready", 64'(rx_ready_o), 64'(1));
         @(posedge clk); #1;
      end
      rx_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("rstmid/wb", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'(0));
      check_eq("rstmid/adr_dat", 64'({wb_adr_o, wb_dat_o}), 64'(0));
      check_eq("rstmid/io", 64'({rx_ready_o, tx_valid_o, tx_data_o}), 64'(0));
      rst = 1'b0;
      set_frame(1'b0, 1, 16'h0005, 0, 0, 0, 1'b0);
      run_frame("after_rst");

      // Random frames.
      for (int t = 0; t < 40; t++) begin
         int r;
         set_frame(1'($urandom_range(1)),
                   $urandom_range(1, ($urandom_range(7) == 0) ? 16 : 4),
                   ($urandom_range(3) == 0) ? 16'hFFFF - 16'($urandom_range(2)) : 16'($urandom),
                   $urandom_range(3), $urandom_range(1, 2) - ($urandom_range(3) == 0 ? 1 : 0),
                   $urandom_range(40), 1'b1);
         f_resv = 3'($urandom);
         for (int i = 0; i < 16; i++) begin
            r = $urandom_range(99);
            f_resp[i] = (r < 6) ? R_ERR : (r < 9) ? R_BOTH : (r < 11) ? R_NONE : R_ACK;
         end
         run_frame($sformatf("rnd%0d", t));
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
